// File: rtl/bf_pkg.sv
// rtl/bf_pkg.sv - shared types and helpers for the output-buffer drain
package bf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    QUANT = 2'd1,
    SEND  = 2'd2
  } drain_state_t;

  localparam int OUT_W_DEFAULT = 8;

  // Column-index width; never narrower than one bit so single-column arrays still elaborate.
  function automatic int col_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bf_quant.sv
// rtl/bf_quant.sv - per-column arithmetic shift, optional ReLU, saturate to OUT_W
module bf_quant import bf_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = OUT_W_DEFAULT
) (
  input  logic [DATA_W-1:0] data_in,
  input  logic [4:0]        shift_amt,
  input  logic              relu_en,
  output logic [OUT_W-1:0]  data_out
);

  localparam logic signed [DATA_W-1:0] MAX_V = {{(DATA_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_V = {{(DATA_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [DATA_W-1:0] shifted;
  logic signed [DATA_W-1:0] rectified;

  always_comb begin
    shifted   = $signed(data_in) >>> shift_amt;
    rectified = (relu_en && shifted[DATA_W-1]) ? '0 : shifted;
    if (rectified > MAX_V) begin
      data_out = MAX_V[OUT_W-1:0];
    end else if (rectified < MIN_V) begin
      data_out = MIN_V[OUT_W-1:0];
    end else begin
      data_out = rectified[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/obuf_drain.sv
// rtl/obuf_drain.sv - captures a finished tile, quantizes all columns, streams them out
module obuf_drain import bf_pkg::*; #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_W     = 32,
  parameter int OUT_W      = OUT_W_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 nRST,
  input  logic [ARRAY_SIZE-1:0][DATA_W-1:0]    acc_sums,
  input  logic                                 tile_done,
  input  logic [4:0]                           shift_amt,
  input  logic                                 relu_en,
  input  logic                                 overrun_clr,
  output logic [ARRAY_SIZE-1:0]                acc_clear,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [OUT_W-1:0]                     out_data,
  output logic [col_w(ARRAY_SIZE)-1:0]         out_col,
  output logic                                 out_last,
  output logic                                 busy,
  output logic                                 overrun
);

  localparam int            CW       = col_w(ARRAY_SIZE);
  localparam logic [CW-1:0] LAST_COL = CW'(ARRAY_SIZE - 1);

  drain_state_t                      state_q, state_d;
  logic [CW-1:0]                     col_q, col_d;
  logic [ARRAY_SIZE-1:0][DATA_W-1:0] shadow_q, shadow_d;
  logic [4:0]                        shift_q, shift_d;
  logic                              relu_q, relu_d;
  logic [ARRAY_SIZE-1:0][OUT_W-1:0]  result_q, result_d;
  logic                              overrun_q, overrun_d;

  logic [ARRAY_SIZE-1:0][OUT_W-1:0]  quant_w;
  logic                              at_last;
  logic                              xfer;
  logic                              accept;

  for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_quant
    bf_quant #(
      .DATA_W (DATA_W),
      .OUT_W  (OUT_W)
    ) u_quant (
      .data_in   (shadow_q[g]),
      .shift_amt (shift_q),
      .relu_en   (relu_q),
      .data_out  (quant_w[g])
    );
  end

  // A new tile is taken when idle, or on the final transfer so tiles can run back to back.
  always_comb begin
    at_last = (col_q == LAST_COL);
    xfer    = (state_q == SEND) && out_ready;
    accept  = tile_done && ((state_q == IDLE) || (xfer && at_last));
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      col_q     <= '0;
      shadow_q  <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      result_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      shadow_q  <= shadow_d;
      shift_q   <= shift_d;
      relu_q    <= relu_d;
      result_q  <= result_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = QUANT;
      QUANT:   state_d = SEND;
      SEND:    if (xfer && at_last) state_d = accept ? QUANT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    shift_d  = shift_q;
    relu_d   = relu_q;
    result_d = result_q;
    col_d    = col_q;
    if (accept) begin
      shadow_d = acc_sums;
      shift_d  = shift_amt;
      relu_d   = relu_en;
    end
    if (state_q == QUANT) begin
      result_d = quant_w;
      col_d    = '0;
    end else if (xfer) begin
      col_d = at_last ? '0 : col_q + CW'(1);
    end
    // A dropped tile_done outranks a same-cycle clear.
    overrun_d = (tile_done && !accept) ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);
  end

  always_comb begin
    acc_clear = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_col   = '0;
    out_last  = 1'b0;
    busy      = (state_q != IDLE);
    overrun   = overrun_q;
    case (state_q)
      QUANT: acc_clear = '1;
      SEND: begin
        out_valid = 1'b1;
        out_data  = result_q[col_q];
        out_col   = col_q;
        out_last  = at_last;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_obuf_drain.sv
// tb/tb_obuf_drain.sv - self-checking bench for obuf_drain
module tb_obuf_drain;
  import bf_pkg::*;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              nRST;
  logic [N-1:0][31:0] acc_sums;
  logic              tile_done;
  logic [4:0]        shift_amt;
  logic              relu_en;
  logic              overrun_clr;
  logic [N-1:0]      acc_clear;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic [1:0]        out_col;
  logic              out_last;
  logic              busy;
  logic              overrun;

  obuf_drain #(.ARRAY_SIZE(N), .DATA_W(32), .OUT_W(8)) dut (
    .clk         (clk),
    .nRST        (nRST),
    .acc_sums    (acc_sums),
    .tile_done   (tile_done),
    .shift_amt   (shift_amt),
    .relu_en     (relu_en),
    .overrun_clr (overrun_clr),
    .acc_clear   (acc_clear),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_col     (out_col),
    .out_last    (out_last),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct packed {
    logic [N-1:0][31:0] sums;
    logic [4:0]         sh;
    logic               relu;
    logic [N-1:0][7:0]  exp;
  } vec_t;

  vec_t tbl[6];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Floor division by 2^sh, then ReLU, then clamp -- straight from the quantization rules.
  function automatic int qmodel(input int v, input int sh, input bit relu);
    longint d = longint'(1) << sh;
    longint r = longint'(v) / d;
    if ((longint'(v) % d != 0) && (v < 0)) r = r - 1;
    if (relu && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return int'(r);
  endfunction

  function automatic vec_t mk(input int s0, input int s1, input int s2, input int s3,
                              input int sh, input bit r,
                              input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v.sums[0] = s0; v.sums[1] = s1; v.sums[2] = s2; v.sums[3] = s3;
    v.sh      = 5'(sh);
    v.relu    = r;
    v.exp[0]  = 8'(e0); v.exp[1] = 8'(e1); v.exp[2] = 8'(e2); v.exp[3] = 8'(e3);
    return v;
  endfunction

  task automatic scramble_inputs();
    for (int c = 0; c < N; c++) acc_sums[c] = $urandom();
    shift_amt = 5'($urandom_range(0, 31));
    relu_en   = 1'($urandom_range(0, 1));
  endtask

  task automatic chk_word(input string tag, input int k, input logic [7:0] ev);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"},  $signed(out_data), $signed(ev));
    chk({tag, "_col"},   out_col, k);
    chk({tag, "_last"},  out_last, (k == N - 1));
    chk({tag, "_clear"}, acc_clear, 0);
  endtask

  task automatic start_tile(input vec_t v, input string tag);
    acc_sums  = v.sums;
    shift_amt = v.sh;
    relu_en   = v.relu;
    tile_done = 1'b1;
    tick();
    tile_done = 1'b0;
    scramble_inputs();
    chk({tag, "_qclear"}, acc_clear, 4'hF);
    chk({tag, "_qvalid"}, out_valid, 0);
    chk({tag, "_qbusy"},  busy, 1);
  endtask

  task automatic drain_tile(input vec_t v, input string tag);
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      tick();
      chk_word(tag, k, v.exp[k]);
    end
    tick();
    chk({tag, "_idle_valid"}, out_valid, 0);
    chk({tag, "_idle_busy"},  busy, 0);
    chk({tag, "_idle_clear"}, acc_clear, 0);
  endtask

  initial begin
    logic [7:0] hd;
    logic [1:0] hc;
    logic       hl;

    tbl[0] = mk(100, -100, 1000, -1000, 2, 0, 25, -25, 127, -128);
    tbl[1] = mk(-1, -7, 7, 0, 1, 1, 0, 0, 3, 0);
    tbl[2] = mk(-2147483647 - 1, 2147483647, 255, -129, 0, 0, -128, 127, 127, -128);
    tbl[3] = mk(-5, 5, -2147483647 - 1, 2147483647, 31, 0, -1, 0, -1, 0);
    tbl[4] = mk(-8, 8, 1023, 1024, 3, 1, 0, 1, 127, 127);
    tbl[5] = mk(-9, -1, -256, -257, 1, 0, -5, -1, -128, -128);

    nRST = 1'b0; acc_sums = '0; tile_done = 1'b0; shift_amt = '0; relu_en = 1'b0;
    overrun_clr = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data, 0);
    chk("rst_col",   out_col, 0);
    chk("rst_last",  out_last, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_ovr",   overrun, 0);
    chk("rst_clear", acc_clear, 0);
    nRST = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      start_tile(tbl[i], $sformatf("tbl%0d", i));
      drain_tile(tbl[i], $sformatf("tbl%0d", i));
    end

    // Backpressure at column 1.
    start_tile(tbl[0], "bp");
    out_ready = 1'b1;
    tick(); chk_word("bp", 0, tbl[0].exp[0]);
    tick(); chk_word("bp", 1, tbl[0].exp[1]);
    out_ready = 1'b0;
    hd = out_data; hc = out_col; hl = out_last;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data",  out_data, hd);
      chk("bp_hold_col",   out_col, hc);
      chk("bp_hold_last",  out_last, hl);
    end
    out_ready = 1'b1;
    tick(); chk_word("bp", 2, tbl[0].exp[2]);
    tick(); chk_word("bp", 3, tbl[0].exp[3]);
    tick(); chk("bp_idle", out_valid, 0);

    // Dropped tile_done while streaming column 1.
    start_tile(tbl[0], "ovr");
    out_ready = 1'b1;
    tick(); chk_word("ovr", 0, tbl[0].exp[0]);
    tick(); chk_word("ovr", 1, tbl[0].exp[1]);
    acc_sums = tbl[2].sums; shift_amt = 5'd0; relu_en = 1'b0; tile_done = 1'b1;
    tick(); tile_done = 1'b0;
    chk("ovr_set", overrun, 1);
    chk_word("ovr", 2, tbl[0].exp[2]);
    tick(); chk_word("ovr", 3, tbl[0].exp[3]);
    tick(); chk("ovr_idle", busy, 0);
    overrun_clr = 1'b1;
    tick(); overrun_clr = 1'b0;
    chk("ovr_clr", overrun, 0);
    start_tile(tbl[1], "ovr2");
    tile_done = 1'b1; overrun_clr = 1'b1;
    tick(); tile_done = 1'b0; overrun_clr = 1'b0;
    chk("ovr_set_wins", overrun, 1);
    chk_word("ovr2", 0, tbl[1].exp[0]);
    tick(); chk_word("ovr2", 1, tbl[1].exp[1]);
    tick(); chk_word("ovr2", 2, tbl[1].exp[2]);
    tick(); chk_word("ovr2", 3, tbl[1].exp[3]);
    tick();
    overrun_clr = 1'b1;
    tick(); overrun_clr = 1'b0;
    chk("ovr_clr2", overrun, 0);

    // Back-to-back tiles: next tile_done lands on the out_last transfer.
    start_tile(tbl[0], "b2b");
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      tick(); chk_word("b2b_a", k, tbl[0].exp[k]);
    end
    acc_sums = tbl[4].sums; shift_amt = tbl[4].sh; relu_en = tbl[4].relu; tile_done = 1'b1;
    tick(); tile_done = 1'b0; scramble_inputs();
    chk("b2b_qclear", acc_clear, 4'hF);
    chk("b2b_qvalid", out_valid, 0);
    chk("b2b_ovr",    overrun, 0);
    drain_tile(tbl[4], "b2b_b");
    chk("b2b_ovr_end", overrun, 0);

    // Reset while streaming column 2.
    start_tile(tbl[0], "rmid");
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("rmid_col_pre", out_col, 2);
    nRST = 1'b0;
    #1;
    chk("rmid_valid", out_valid, 0);
    chk("rmid_data",  out_data, 0);
    chk("rmid_col",   out_col, 0);
    chk("rmid_last",  out_last, 0);
    chk("rmid_busy",  busy, 0);
    chk("rmid_clear", acc_clear, 0);
    for (int s = 0; s < 2; s++) begin
      tick();
      chk("rmid_hold_valid", out_valid, 0);
      chk("rmid_hold_clear", acc_clear, 0);
    end
    nRST = 1'b1;
    tick();
    chk("rmid_after_valid", out_valid, 0);
    start_tile(tbl[2], "rpost");
    drain_tile(tbl[2], "rpost");

    // Randomized tiles with random backpressure and stray tile_done pulses.
    for (int t = 0; t < 40; t++) begin
      vec_t v;
      int   e[N];
      int   k;
      int   budget;
      bit   exp_ovr;
      bit   prev_stall;
      logic [7:0] pd;
      logic [1:0] pc;
      for (int c = 0; c < N; c++) begin
        case ($urandom_range(0, 2))
          0: v.sums[c] = $urandom();
          1: v.sums[c] = 32'($signed($urandom_range(0, 600)) - 300);
          default: v.sums[c] = 32'($signed($urandom_range(0, 20000)) - 10000);
        endcase
      end
      v.sh   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 8));
      v.relu = 1'($urandom_range(0, 1));
      for (int c = 0; c < N; c++) e[c] = qmodel($signed(v.sums[c]), int'(v.sh), v.relu);
      start_tile(v, "rnd");
      k = 0; budget = 0; exp_ovr = 1'b0; prev_stall = 1'b0; pd = '0; pc = '0;
      while (k < N && budget < 200) begin
        tile_done = 1'b0;
        if (out_valid) begin
          if (prev_stall) begin
            chk("rnd_hold_data", out_data, pd);
            chk("rnd_hold_col",  out_col, pc);
          end
          chk("rnd_data", $signed(out_data), e[k]);
          chk("rnd_col",  out_col, k);
          chk("rnd_last", out_last, (k == N - 1));
        end
        out_ready = 1'($urandom_range(0, 1));
        if (!(out_valid && k == N - 1 && out_ready) && $urandom_range(0, 7) == 0) begin
          scramble_inputs();
          tile_done = 1'b1;
          exp_ovr   = 1'b1;
        end
        prev_stall = out_valid && !out_ready;
        pd = out_data; pc = out_col;
        if (out_valid && out_ready) k++;
        budget++;
        tick();
      end
      tile_done = 1'b0;
      out_ready = 1'b0;
      chk("rnd_complete", k, N);
      chk("rnd_idle", busy, 0);
      chk("rnd_ovr", overrun, exp_ovr);
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
